ffu_playback_checker: RTL and testbench



---
 rtl/ffu_playback_checker.sv | 143 ++++++++++++++
 tb/tb_ffu_playback_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ffu_playback_checker.sv
// rtl/ffu_playback_checker.sv - replays captured FFU vectors into a sparc_ffu and checks its outputs
// Optional PLAYBACK_STOP_ON_ERR_EN: end the run on the first compared mismatch.
module ffu_playback_checker #(
  parameter int IN_W  = 269,
  parameter int OUT_W = 198,
  parameter int AW    = 8
) (
  input  logic               rclk,
  input  logic               arst_l,
  input  logic               load_vld,
  input  logic [AW-1:0]      load_addr,
  input  logic [IN_W:0]      load_in,
  input  logic [OUT_W-1:0]   load_out,
  input  logic               start,
  input  logic [AW:0]        num_vec,
  output logic [IN_W-1:0]    dut_in,
  input  logic [OUT_W-1:0]   dut_out,
  output logic               vec_vld,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_cnt,
  output logic [AW:0]        first_err_idx
);

  localparam int EW    = IN_W + 1 + OUT_W;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [EW-1:0]     mem [DEPTH];
  logic [AW:0]       rd_ptr;
  logic [AW:0]       num_lat;
  logic [AW:0]       vec_idx;
  logic [OUT_W-1:0]  exp_q;
  logic              phase_q;
  logic              ready;
  logic              start_acc;
  logic              wr_en;
  logic              last_rd;
  logic              mism;
  logic              stop;
  logic [AW-1:0]     ram_addr;
  logic [EW-1:0]     ram_q;

  assign ready     = (state == S_IDLE) || (state == S_DONE);
  assign start_acc = start && ready;
  assign wr_en     = load_vld && !start && ready;
  assign last_rd   = (rd_ptr == num_lat - (AW+1)'(1));
  // Single port: writes only happen outside RUN, so the address can be shared.
  assign ram_addr  = wr_en ? load_addr : rd_ptr[AW-1:0];
  assign ram_q     = mem[ram_addr];
  assign mism      = vec_vld && phase_q && (dut_out != exp_q);

`ifdef PLAYBACK_STOP_ON_ERR_EN
  assign stop = mism;
`else
  assign stop = 1'b0;
`endif

  always_ff @(posedge rclk) begin
    if (wr_en) begin
      mem[ram_addr] <= {load_in, load_out};
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = (num_vec == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_DONE;
        end else if (last_rd) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN) || (state == S_DRAIN);
    done = (state == S_DONE);
    pass = (state == S_DONE) && (err_cnt == 16'd0);
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      rd_ptr        <= '0;
      num_lat       <= '0;
      err_cnt       <= 16'd0;
      first_err_idx <= '1;
      vec_vld       <= 1'b0;
      dut_in        <= '0;
      exp_q         <= '0;
      phase_q       <= 1'b0;
      vec_idx       <= '0;
    end else begin
      if (start_acc) begin
        rd_ptr        <= '0;
        num_lat       <= num_vec;
        err_cnt       <= 16'd0;
        first_err_idx <= '1;
      end else begin
        if (state == S_RUN) begin
          rd_ptr <= rd_ptr + (AW+1)'(1);
        end
        if (mism) begin
          if (err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
          end
          if (&first_err_idx) begin
            first_err_idx <= vec_idx;
          end
        end
      end
      // A stop discards the read issued in the same cycle.
      vec_vld <= (state == S_RUN) && !stop;
      if ((state == S_RUN) && !stop) begin
        phase_q <= ram_q[EW-1];
        dut_in  <= ram_q[EW-2:OUT_W];
        exp_q   <= ram_q[OUT_W-1:0];
        vec_idx <= rd_ptr;
      end
    end
  end

endmodule

// File: tb/tb_ffu_playback_checker.sv
// tb/tb_ffu_playback_checker.sv - directed bench for ffu_playback_checker
module tb_ffu_playback_checker;

  localparam int IN_W  = 269;
  localparam int OUT_W = 198;
  localparam int AW    = 8;
  localparam logic [AW:0] IDX_NONE = '1;

  logic               rclk;
  logic               arst_l;
  logic               load_vld;
  logic [AW-1:0]      load_addr;
  logic [IN_W:0]      load_in;
  logic [OUT_W-1:0]   load_out;
  logic               start;
  logic [AW:0]        num_vec;
  logic [IN_W-1:0]    dut_in;
  logic [OUT_W-1:0]   dut_out;
  logic               vec_vld;
  logic               busy;
  logic               done;
  logic               pass;
  logic [15:0]        err_cnt;
  logic [AW:0]        first_err_idx;

  logic [OUT_W-1:0]   exp_pat;
  int                 checks;
  int                 failures;
  int                 nvld;
  int                 done_cyc;
  int                 first_vld;
  logic               busy0;
  logic [IN_W-1:0]    slot [16];

  ffu_playback_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .AW(AW)) dut (
    .rclk(rclk), .arst_l(arst_l), .load_vld(load_vld), .load_addr(load_addr),
    .load_in(load_in), .load_out(load_out), .start(start), .num_vec(num_vec),
    .dut_in(dut_in), .dut_out(dut_out), .vec_vld(vec_vld), .busy(busy),
    .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [IN_W-1:0] in_word(input int i);
    logic [IN_W-1:0] w;
    w = '0;
    w[15:0] = 16'hA500 + i[15:0];
    w[137] = i[0];
    w[IN_W-1] = 1'b1;
    return w;
  endfunction

  task automatic load_entry(input int a, input logic ph, input logic [IN_W-1:0] w,
                            input logic [OUT_W-1:0] e);
    @(posedge rclk); #1;
    load_vld = 1'b1;
    load_addr = a[AW-1:0];
    load_in = {ph, w};
    load_out = e;
    @(posedge rclk); #1;
    load_vld = 1'b0;
  endtask

  task automatic run_replay(input int n, input bit collide, input int busy_c, input int abort_c);
    nvld = 0;
    done_cyc = -1;
    first_vld = -1;
    busy0 = 1'b0;
    @(posedge rclk); #1;
    start = 1'b1;
    num_vec = n[AW:0];
    if (collide) begin
      load_vld = 1'b1;
      load_addr = '0;
      load_in = {1'b1, in_word(0)};
      load_out = ~exp_pat;
    end
    @(posedge rclk); #1;
    start = 1'b0;
    load_vld = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == busy_c) begin
        start = 1'b1;
        num_vec = 1;
      end else begin
        start = 1'b0;
      end
      if (c == 0) busy0 = busy;
      if (vec_vld) begin
        if (first_vld < 0) first_vld = c;
        if (nvld < 16) slot[nvld] = dut_in;
        nvld++;
      end
      if (done && done_cyc < 0) done_cyc = c;
      if (c == abort_c) begin
        arst_l = 1'b0;
        #2;
        return;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      @(posedge rclk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    arst_l = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    arst_l = 1'b1;
    @(posedge rclk); #1;
    checks++; if (dut_in !== '0) begin failures++; $display("FAIL reset_dut_in got=%0h exp=0", dut_in); end
    checks++; if ({vec_vld, busy, done, pass} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {vec_vld, busy, done, pass}); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err_cnt got=%0h exp=0", err_cnt); end
    checks++; if (first_err_idx !== IDX_NONE) begin failures++; $display("FAIL reset_first_idx got=%0h exp=%0h", first_err_idx, IDX_NONE); end
  endtask

  task automatic test_pass;
    for (int i = 0; i < 4; i++) load_entry(i, 1'b1, in_word(i), exp_pat);
    run_replay(4, 1'b0, -1, -1);
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL pass_busy got=%b exp=1", busy0); end
    checks++; if (first_vld !== 1) begin failures++; $display("FAIL pass_first_vld got=%0d exp=1", first_vld); end
    checks++; if (nvld !== 4) begin failures++; $display("FAIL pass_nvld got=%0d exp=4", nvld); end
    checks++; if (done_cyc !== 5) begin failures++; $display("FAIL pass_done_cyc got=%0d exp=5", done_cyc); end
    checks++; if (pass !== 1'b1 || err_cnt !== 16'd0) begin failures++; $display("FAIL pass_result got=%b/%0h exp=1/0", pass, err_cnt); end
    checks++; if (first_err_idx !== IDX_NONE) begin failures++; $display("FAIL pass_first_idx got=%0h exp=%0h", first_err_idx, IDX_NONE); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (slot[i] !== in_word(i)) begin failures++; $display("FAIL pass_slot%0d got=%0h exp=%0h", i, slot[i], in_word(i)); end
    end
    checks++; if (vec_vld !== 1'b0 || busy !== 1'b0 || dut_in !== in_word(3)) begin failures++; $display("FAIL pass_hold got=%b/%b/%0h exp=0/0/%0h", vec_vld, busy, dut_in, in_word(3)); end
  endtask

  task automatic test_mismatch;
    int exp_n;
    int exp_done;
    logic [IN_W-1:0] exp_last;
    load_entry(2, 1'b1, in_word(2), exp_pat ^ OUT_W'(1));
    run_replay(4, 1'b0, -1, -1);
`ifdef PLAYBACK_STOP_ON_ERR_EN
    exp_n = 3; exp_done = 4; exp_last = in_word(2);
`else
    exp_n = 4; exp_done = 5; exp_last = in_word(3);
`endif
    checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL mism_err_cnt got=%0h exp=1", err_cnt); end
    checks++; if (first_err_idx !== 9'd2) begin failures++; $display("FAIL mism_first_idx got=%0h exp=2", first_err_idx); end
    checks++; if (pass !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL mism_pass got=%b/%b exp=0/1", pass, done); end
    checks++; if (nvld !== exp_n) begin failures++; $display("FAIL mism_nvld got=%0d exp=%0d", nvld, exp_n); end
    checks++; if (done_cyc !== exp_done) begin failures++; $display("FAIL mism_done_cyc got=%0d exp=%0d", done_cyc, exp_done); end
    checks++; if (dut_in !== exp_last) begin failures++; $display("FAIL mism_last_in got=%0h exp=%0h", dut_in, exp_last); end
    load_entry(2, 1'b1, in_word(2), exp_pat);
  endtask

  task automatic test_zero;
    run_replay(0, 1'b0, -1, -1);
    checks++; if (done_cyc !== 0) begin failures++; $display("FAIL zero_done_cyc got=%0d exp=0", done_cyc); end
    checks++; if (nvld !== 0) begin failures++; $display("FAIL zero_nvld got=%0d exp=0", nvld); end
    checks++; if (pass !== 1'b1 || err_cnt !== 16'd0) begin failures++; $display("FAIL zero_result got=%b/%0h exp=1/0", pass, err_cnt); end
    checks++; if (first_err_idx !== IDX_NONE) begin failures++; $display("FAIL zero_first_idx got=%0h exp=%0h", first_err_idx, IDX_NONE); end
  endtask

  task automatic test_phase0;
    load_entry(1, 1'b0, in_word(1), ~exp_pat);
    run_replay(4, 1'b0, -1, -1);
    checks++; if (pass !== 1'b1 || err_cnt !== 16'd0) begin failures++; $display("FAIL ph0_result got=%b/%0h exp=1/0", pass, err_cnt); end
    checks++; if (slot[1] !== in_word(1)) begin failures++; $display("FAIL ph0_slot1 got=%0h exp=%0h", slot[1], in_word(1)); end
    checks++; if (nvld !== 4) begin failures++; $display("FAIL ph0_nvld got=%0d exp=4", nvld); end
    load_entry(1, 1'b1, in_word(1), exp_pat);
  endtask

  task automatic test_reset_mid_run;
    for (int i = 4; i < 8; i++) load_entry(i, 1'b1, in_word(i), exp_pat);
    run_replay(8, 1'b0, -1, 3);
    checks++; if (nvld !== 3) begin failures++; $display("FAIL rst_nvld got=%0d exp=3", nvld); end
    checks++; if (dut_in !== '0) begin failures++; $display("FAIL rst_dut_in got=%0h exp=0", dut_in); end
    checks++; if ({vec_vld, busy, done, pass} !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {vec_vld, busy, done, pass}); end
    checks++; if (err_cnt !== 16'd0 || first_err_idx !== IDX_NONE) begin failures++; $display("FAIL rst_counters got=%0h/%0h exp=0/%0h", err_cnt, first_err_idx, IDX_NONE); end
    @(posedge rclk); #1;
    arst_l = 1'b1;
    run_replay(8, 1'b0, -1, -1);
    checks++; if (nvld !== 8 || done_cyc !== 9) begin failures++; $display("FAIL rerun_len got=%0d/%0d exp=8/9", nvld, done_cyc); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL rerun_pass got=%b exp=1", pass); end
    checks++; if (slot[0] !== in_word(0) || slot[7] !== in_word(7)) begin failures++; $display("FAIL rerun_slots got=%0h/%0h exp=%0h/%0h", slot[0], slot[7], in_word(0), in_word(7)); end
  endtask

  task automatic test_collision;
    arst_l = 1'b0;
    @(posedge rclk); #1;
    arst_l = 1'b1;
    run_replay(4, 1'b1, 2, -1);
    checks++; if (pass !== 1'b1 || err_cnt !== 16'd0) begin failures++; $display("FAIL coll_result got=%b/%0h exp=1/0", pass, err_cnt); end
    checks++; if (nvld !== 4 || done_cyc !== 5) begin failures++; $display("FAIL coll_len got=%0d/%0d exp=4/5", nvld, done_cyc); end
    run_replay(1, 1'b0, -1, -1);
    checks++; if (pass !== 1'b1 || slot[0] !== in_word(0)) begin failures++; $display("FAIL coll_entry0 got=%b/%0h exp=1/%0h", pass, slot[0], in_word(0)); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_pat = {6'h2A, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F0F00FF0F0FF0F0};
    dut_out = exp_pat;
    arst_l = 1'b0;
    load_vld = 1'b0;
    load_addr = '0;
    load_in = '0;
    load_out = '0;
    start = 1'b0;
    num_vec = '0;
    test_reset;
    test_pass;
    test_mismatch;
    test_zero;
    test_phase0;
    test_reset_mid_run;
    test_collision;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
